// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_rx
//  Description : WS2812B single-wire NRZ receiver. Classifies high pulses by
//                width, assembles GRB words, reorders them to RGB and commits
//                up to NUM pixels into a frame buffer on the latch gap.
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_rx #(
  parameter int NUM          = 8,
  parameter int MIN_HIGH     = 15,
  parameter int THRESH       = 60,
  parameter int MAX_HIGH     = 110,
  parameter int LATCH_CYCLES = 5000
) (
  input  logic                       clock_100,
  input  logic                       clear_n,
  input  logic                       din,
  output logic [24*NUM-1:0]          rgb_strip,
  output logic [23:0]                pixel_rgb,
  output logic                       pixel_valid,
  output logic [$clog2(NUM+1)-1:0]   pixel_count,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       error
);

  localparam int IW = $clog2(NUM + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    IDLE       = 2'd1,
    LOW        = 2'd2,
    HIGH       = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;

  logic                sync1;
  logic                sync2;
  logic                sync_prev;
  logic                rise;

  logic [LW-1:0]       low_cnt;
  logic [HW-1:0]       high_cnt;
  logic [4:0]          bit_cnt;
  logic [22:0]         shift;
  logic [IW-1:0]       idx;
  logic [24*NUM-1:0]   shadow;

  // control strobes from the state machine
  logic                low_rst;
  logic                low_set1;
  logic                low_inc;
  logic                high_start;
  logic                high_inc;
  logic                accept_bit;
  logic                bit_val;
  logic                too_long;
  logic                latch_evt;

  logic [23:0]         word_grb;
  logic [23:0]         word_rgb;
  logic                low_at_max;
  logic                low_last;

  assign rise       = sync2 & ~sync_prev;
  assign low_at_max = (low_cnt == LW'(LATCH_CYCLES));
  assign low_last   = (low_cnt == LW'(LATCH_CYCLES - 1));
  assign word_grb   = {shift, bit_val};
  assign word_rgb   = {word_grb[15:8], word_grb[23:16], word_grb[7:0]};

  // Two-flop synchronizer for the asynchronous pin plus a delayed copy for edges
  always_ff @(posedge clock_100 or negedge clear_n) begin
    if (!clear_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // State register
  always_ff @(posedge clock_100 or negedge clear_n) begin
    if (!clear_n) begin
      state <= WAIT_LATCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    low_rst    = 1'b0;
    low_set1   = 1'b0;
    low_inc    = 1'b0;
    high_start = 1'b0;
    high_inc   = 1'b0;
    accept_bit = 1'b0;
    bit_val    = 1'b0;
    too_long   = 1'b0;
    latch_evt  = 1'b0;
    case (state)
      WAIT_LATCH: begin
        // any high sample restarts the quiet-time measurement
        if (sync2) begin
          low_rst = 1'b1;
        end else begin
          low_inc = !low_at_max;
          if (low_last) begin
            state_next = IDLE;
          end
        end
      end
      IDLE, LOW: begin
        if (rise) begin
          high_start = 1'b1;
          state_next = HIGH;
        end else if (!sync2) begin
          low_inc = !low_at_max;
          // fires only on the transition into saturation: once per gap
          if (low_last) begin
            latch_evt  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      HIGH: begin
        if (sync2) begin
          // this sample would make the pulse longer than MAX_HIGH
          if (high_cnt >= HW'(MAX_HIGH)) begin
            too_long   = 1'b1;
            low_rst    = 1'b1;
            state_next = WAIT_LATCH;
          end else begin
            high_inc = 1'b1;
          end
        end else begin
          low_set1   = 1'b1;
          state_next = LOW;
          if (high_cnt >= HW'(MIN_HIGH)) begin
            accept_bit = 1'b1;
            bit_val    = (high_cnt >= HW'(THRESH));
          end
        end
      end
      default: begin
        state_next = WAIT_LATCH;
      end
    endcase
  end

  // Width/low counters, bit assembly, shadow buffer, commit and status pulses
  always_ff @(posedge clock_100 or negedge clear_n) begin
    if (!clear_n) begin
      low_cnt     <= '0;
      high_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      idx         <= '0;
      shadow      <= '0;
      rgb_strip   <= '0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      if (low_rst) begin
        low_cnt <= '0;
      end else if (low_set1) begin
        low_cnt <= LW'(1);
      end else if (low_inc) begin
        low_cnt <= low_cnt + LW'(1);
      end

      // the rising-edge sample itself is the first high clock
      if (high_start) begin
        high_cnt <= HW'(1);
      end else if (high_inc) begin
        high_cnt <= high_cnt + HW'(1);
      end

      // data seen before a proper gap never belongs to a frame
      if (state == WAIT_LATCH) begin
        bit_cnt <= '0;
        idx     <= '0;
      end

      if (too_long) begin
        error   <= 1'b1;
        bit_cnt <= '0;
      end

      if (accept_bit) begin
        shift <= word_grb[22:0];
        // first bit of a new frame releases the previous overflow flag
        if (bit_cnt == 5'd0 && idx == '0) begin
          overflow <= 1'b0;
        end
        if (bit_cnt == 5'd23) begin
          bit_cnt     <= '0;
          pixel_rgb   <= word_rgb;
          pixel_valid <= 1'b1;
          if (idx < IW'(NUM)) begin
            for (int i = 0; i < NUM; i++) begin
              if (idx == IW'(i)) begin
                shadow[24*(NUM-1-i) +: 24] <= word_rgb;
              end
            end
            idx <= idx + IW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (latch_evt) begin
        if (bit_cnt != 5'd0) begin
          error <= 1'b1;
        end
        bit_cnt <= '0;
        if (idx != '0) begin
          // slots at or above idx keep their previously committed contents
          for (int i = 0; i < NUM; i++) begin
            if (IW'(i) < idx) begin
              rgb_strip[24*(NUM-1-i) +: 24] <= shadow[24*(NUM-1-i) +: 24];
            end
          end
          pixel_count <= idx;
          frame_done  <= 1'b1;
        end
        idx <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receiver/decoder for the single-wire WS2812B NRZ LED protocol.
- Samples a data line and classifies each high pulse by width as a 0 or 1 bit. Assembles 24-bit GRB words and reorders them to RGB. Writes up to NUM pixels into a frame buffer that updates only on the 50 us latch gap.
- Used as a loopback checker for the LED-strip driver and as an input port for external WS2812-format controllers.
- Output strip layout matches the driver's input: first pixel in the MSBs, 8 bits each R, G, B.

Parameters:
NUM, 8, number of pixels held in the frame buffer
MIN_HIGH, 15, high pulses shorter than this many clocks are glitches and are ignored
THRESH, 60, high width >= THRESH clocks decodes as 1, otherwise 0
MAX_HIGH, 110, high width > MAX_HIGH clocks is a protocol error
LATCH_CYCLES, 5000, low time in clocks (50 us at 100 MHz) that ends a frame

Ports:
clock_100  in  1  100 MHz clock
clear_n  in  1  asynchronous active-low reset
din  in  1  asynchronous WS2812 data line from pin
rgb_strip  out  24*NUM  last committed frame; pixel 0 in [24*NUM-1 : 24*(NUM-1)]
pixel_rgb  out  24  most recently decoded pixel, RGB order
pixel_valid  out  1  one-cycle pulse when pixel_rgb updates
pixel_count  out  clog2(NUM+1)  pixels committed in last frame, saturates at NUM
frame_done  out  1  one-cycle pulse when rgb_strip is committed
overflow  out  1  sticky: more than NUM pixels in the current or last frame
error  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: rgb_strip, pixel_rgb and pixel_count are 0. All pulses and overflow are 0. Shadow buffer, bit and pixel counters are 0. State is WAIT_LATCH.
- Input path: din passes through a 2-flop synchronizer, then an edge detector. Decisions have a 3-clock latency from a din edge.
- WAIT_LATCH: ignore data and count low time. When low time reaches LATCH_CYCLES, go to IDLE with no commit and no frame_done. Any high sample restarts the count.
- IDLE/LOW: a rising edge clears the width counter and moves to HIGH. The low counter saturates at LATCH_CYCLES. Reaching it triggers the latch event (below) exactly once per gap.
- HIGH: count clocks while high.
  - If the count exceeds MAX_HIGH, pulse error, drop the partial pixel and go to WAIT_LATCH. Do not wait for the falling edge.
- Falling edge with width w:
  - w < MIN_HIGH: glitch. Discard it with no bit and keep the partial pixel.
  - Otherwise shift bit (w >= THRESH) into a 24-bit register, MSB first, then go to LOW.
- 24th bit:
  - Wire order is G,R,B. pixel_rgb = {R,G,B}, and pixel_valid pulses the next clock.
  - If index < NUM, write the pixel to shadow slot index and increment index.
  - If index == NUM, discard the pixel and set overflow.
  - Clear the bit counter.
- Latch event:
  - If the bit counter is nonzero: pulse error and discard the partial bits.
  - If index > 0: copy shadow to rgb_strip, set pixel_count = index and pulse frame_done in the same cycle. Slots at or above index keep their previous committed values.
  - If index == 0: no commit and no frame_done.
  - Clear index. overflow holds its value through this commit and clears at the first bit of the next frame.
- Error and frame_done can pulse in the same cycle (partial pixel after valid pixels).
- A reset mid-frame returns everything to the reset state. The committed frame is lost.

Test Plan:
- Reset, then din low for 5000 clocks. Send pixels 0xFF0000, 0x00FF00 and 0x0000FF: wire GRB 0x00FF00, 0xFF0000, 0x0000FF, each bit 30/95 high/low for 0 and 80/45 for 1. Hold low 5000 clocks. Expected: three pixel_valid pulses with those RGB values; frame_done once; pixel_count=3; rgb_strip[191:120]=0xFF0000_00FF00_0000FF; lower slots 0.
- Boundary widths. High 59 and 60 decode to 0 and 1. High 14 is ignored and leaves the bit count unchanged. High 111 pulses error, and the next 5000-clock low gives no frame_done.
- Send NUM+2=10 pixels, then latch. Expected: 10 pixel_valid pulses; overflow=1; pixel_count=8; rgb_strip holds the first 8 pixels.
- Send 1 pixel plus 5 bits, then latch. Expected: error and frame_done pulse in the same cycle; pixel_count=1.
- Start stimulus mid-bit right after reset without the initial gap. Expected: no pixel_valid until a 5000-clock low is seen.
- Assert clear_n low for 1 clock mid-pixel. Expected: all outputs 0 immediately. A following full frame decodes correctly.
- Loopback: drive din from the LED-strip driver with NUM=8 and a random rgb_strip. Expected: frame_done, and the received rgb_strip equals the transmitted one.
